// File: rtl/reg_file_pkg.sv
// Shared constants and sequencer state encoding for the scoreboarded register file.
package reg_file_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/reg_file_clear_ctrl.sv
// Clear sequencer: walks idx over every entry once per clear request.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  ST_IDLE  | normal operation, ready high, clr_req accepted
//  ST_CLEAR | zeroing entry clr_idx each cycle, ready low, inputs ignored
module reg_file_clear_ctrl
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              ready,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    clr_state_e        state_q;
    clr_state_e        state_d;
    logic [ADDR_W-1:0] idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            // Wraps to zero naturally on the last entry, so IDLE always restarts at 0.
            idx_q   <= (state_q == ST_CLEAR) ? idx_q + 1'b1 : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (clr_req) state_d = ST_CLEAR;
            ST_CLEAR: if (idx_q == LAST_IDX) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready   = (state_q == ST_IDLE);
        clr_en  = (state_q == ST_CLEAR);
        clr_idx = idx_q;
    end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read-port register file with per-entry busy scoreboard, write-back bypass
// and a sequenced whole-file clear.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              ready,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_idx;
    logic              wb_ok;
    logic              iss_ok;

    reg_file_clear_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .ready   (ready),
        .clr_en  (clr_en),
        .clr_idx (clr_idx)
    );

    always_comb begin
        wb_ok  = ready && wb_valid  && !((ZERO_REG != 0) && (wb_addr  == '0));
        iss_ok = ready && iss_valid && !((ZERO_REG != 0) && (iss_addr == '0));
    end

    // Issue is applied after write-back so a same-address pair leaves the entry busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy <= '0;
        end else if (clr_en) begin
            regs[clr_idx] <= '0;
            busy[clr_idx] <= 1'b0;
        end else begin
            if (wb_ok) begin
                regs[wb_addr] <= wb_data;
                busy[wb_addr] <= 1'b0;
            end
            if (iss_ok) busy[iss_addr] <= 1'b1;
        end
    end

    logic [ADDR_W-1:0] port_addr [2];
    logic [DATA_W-1:0] port_data [2];
    logic              port_busy [2];

    assign port_addr[0] = rd_addr_a;
    assign port_addr[1] = rd_addr_b;

    for (genvar p = 0; p < 2; p++) begin : g_read
        always_comb begin
            port_data[p] = regs[port_addr[p]];
            port_busy[p] = busy[port_addr[p]];
            if ((ZERO_REG != 0) && (port_addr[p] == '0)) begin
                port_data[p] = '0;
                port_busy[p] = 1'b0;
            end else if ((BYPASS != 0) && wb_ok && (wb_addr == port_addr[p])) begin
                port_data[p] = wb_data;
                port_busy[p] = 1'b0;
            end
        end
    end

    assign rd_data_a = port_data[0];
    assign rd_busy_a = port_busy[0];
    assign rd_data_b = port_data[1];
    assign rd_busy_b = port_busy[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized and directed bench for reg_file_sb: three instances (default,
// no bypass, zero register) share stimulus and are compared with a behavioural model.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_req;
    logic [3:0]  rd_addr_a, rd_addr_b, iss_addr, wb_addr;
    logic        iss_valid, wb_valid;
    logic [15:0] wb_data;

    logic        rdy [3];
    logic [15:0] rda [3];
    logic [15:0] rdb [3];
    logic        bsa [3];
    logic        bsb [3];

    int checks = 0;
    int errors = 0;

    int  mreg  [3][16];
    bit  mbusy [3][16];
    bit  clearing;
    int  cpos;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u_dut_def (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(rdy[0]),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda[0]), .rd_data_b(rdb[0]), .rd_busy_a(bsa[0]), .rd_busy_b(bsb[0]),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data));

    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) u_dut_nobyp (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(rdy[1]),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda[1]), .rd_data_b(rdb[1]), .rd_busy_a(bsa[1]), .rd_busy_b(bsb[1]),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data));

    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u_dut_zr (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(rdy[2]),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda[2]), .rd_data_b(rdb[2]), .rd_busy_a(bsa[2]), .rd_busy_b(bsb[2]),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 16; a++) begin
                mreg[k][a]  = 0;
                mbusy[k][a] = 0;
            end
        clearing = 0;
        cpos     = 0;
    endtask

    // Instance 1 has no bypass, instance 2 hardwires register 0.
    function automatic logic [16:0] exp_rd(input int k, input int addr);
        bit zr = (k == 2);
        bit bp = (k != 1);
        if (zr && addr == 0) return 17'h0;
        if (bp && !clearing && wb_valid && int'(wb_addr) == addr) return {1'b0, wb_data};
        return {mbusy[k][addr], 16'(mreg[k][addr])};
    endfunction

    task automatic compare_all();
        logic [16:0] e;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ready%0d", k), 32'(rdy[k]), 32'(!clearing));
            e = exp_rd(k, int'(rd_addr_a));
            check($sformatf("rd_data_a%0d", k), 32'(rda[k]), 32'(e[15:0]));
            check($sformatf("rd_busy_a%0d", k), 32'(bsa[k]), 32'(e[16]));
            e = exp_rd(k, int'(rd_addr_b));
            check($sformatf("rd_data_b%0d", k), 32'(rdb[k]), 32'(e[15:0]));
            check($sformatf("rd_busy_b%0d", k), 32'(bsb[k]), 32'(e[16]));
        end
    endtask

    task automatic model_update();
        if (rst) return;
        if (!clearing) begin
            for (int k = 0; k < 3; k++) begin
                if (wb_valid && !(k == 2 && wb_addr == 0)) begin
                    mreg[k][wb_addr]  = int'(wb_data);
                    mbusy[k][wb_addr] = 0;
                end
                if (iss_valid && !(k == 2 && iss_addr == 0)) mbusy[k][iss_addr] = 1;
            end
            if (clr_req) begin
                clearing = 1;
                cpos     = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                mreg[k][cpos]  = 0;
                mbusy[k][cpos] = 0;
            end
            cpos++;
            if (cpos == 16) clearing = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        clr_req   = 1'b0;
        iss_valid = 1'b0;
        wb_valid  = 1'b0;
    endtask

    task automatic rand_inputs(input int clr_odds);
        rd_addr_a = 4'($urandom_range(0, 15));
        rd_addr_b = 4'($urandom_range(0, 15));
        iss_valid = 1'($urandom_range(0, 1));
        iss_addr  = 4'($urandom_range(0, 15));
        wb_valid  = 1'($urandom_range(0, 1));
        wb_addr   = ($urandom_range(0, 3) == 0) ? iss_addr : 4'($urandom_range(0, 15));
        wb_data   = 16'($urandom);
        clr_req   = (clr_odds > 0) ? ($urandom_range(0, clr_odds - 1) == 0) : 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        idle_inputs();
        rd_addr_a = '0; rd_addr_b = '0; iss_addr = '0; wb_addr = '0; wb_data = '0;
        model_reset();

        // Reset state, with the async reset still held.
        #1;
        check("rst_ready", 32'(rdy[0]), 32'd1);
        check("rst_rd_a", 32'(rda[0]), 32'd0);
        check("rst_busy_a", 32'(bsa[0]), 32'd0);
        step();
        step();
        rst = 1'b0;

        // Write-back then read the next cycle.
        wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 16'h1234; rd_addr_a = 4'd5;
        step();
        wb_valid = 1'b0;
        #1;
        check("wb_r5_data", 32'(rda[0]), 32'h1234);
        check("wb_r5_busy", 32'(bsa[0]), 32'd0);
        step();

        // Issue r3, then write-back with bypass vs no bypass.
        iss_valid = 1'b1; iss_addr = 4'd3; rd_addr_b = 4'd3;
        step();
        iss_valid = 1'b0;
        #1;
        check("iss_r3_busy", 32'(bsb[0]), 32'd1);
        wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 16'hBEEF;
        #1;
        check("byp_r3_data", 32'(rdb[0]), 32'hBEEF);
        check("byp_r3_busy", 32'(bsb[0]), 32'd0);
        check("nobyp_r3_data", 32'(rdb[1]), 32'h0);
        check("nobyp_r3_busy", 32'(bsb[1]), 32'd1);
        step();
        wb_valid = 1'b0;
        #1;
        check("nobyp_r3_next", 32'(rdb[1]), 32'hBEEF);
        check("nobyp_r3_nbusy", 32'(bsb[1]), 32'd0);

        // Issue and write-back to the same register: issue wins on busy.
        iss_valid = 1'b1; iss_addr = 4'd7; wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 16'h00FF;
        rd_addr_a = 4'd7;
        step();
        idle_inputs();
        #1;
        check("r7_data", 32'(rda[0]), 32'h00FF);
        check("r7_busy", 32'(bsa[0]), 32'd1);

        // Register 0 hardwired on the zero-register instance, including the bypass path.
        iss_valid = 1'b1; iss_addr = 4'd0; wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF;
        rd_addr_a = 4'd0;
        #1;
        check("zr_byp_data", 32'(rda[2]), 32'h0);
        check("zr_byp_busy", 32'(bsa[2]), 32'd0);
        step();
        idle_inputs();
        #1;
        check("zr_r0_data", 32'(rda[2]), 32'h0);
        check("zr_r0_busy", 32'(bsa[2]), 32'd0);
        check("def_r0_data", 32'(rda[0]), 32'hFFFF);
        check("def_r0_busy", 32'(bsa[0]), 32'd1);

        // Fill the file, then clear with traffic that must be ignored.
        for (int a = 0; a < 16; a++) begin
            wb_valid = 1'b1; wb_addr = 4'(a); wb_data = 16'($urandom_range(1, 65535));
            iss_valid = 1'($urandom_range(0, 1)); iss_addr = 4'(a);
            rd_addr_a = 4'(a); rd_addr_b = 4'($urandom_range(0, 15));
            step();
        end
        clr_req = 1'b1; wb_valid = 1'b1; iss_valid = 1'b1;
        step();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (rdy[0]) break;
            cnt++;
            rand_inputs(2);
            step();
        end
        check("clr_len", 32'(cnt), 32'd16);
        idle_inputs();
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = 4'(a);
            rd_addr_b = 4'(15 - a);
            #1;
            check("clr_rd_a", 32'({bsa[0], rda[0]}), 32'h0);
            step();
        end

        // Async reset part-way through a clear.
        for (int a = 0; a < 16; a++) begin
            wb_valid = 1'b1; wb_addr = 4'(a); wb_data = 16'($urandom_range(1, 65535));
            step();
        end
        idle_inputs();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        model_reset();
        rd_addr_a = 4'd12; rd_addr_b = 4'd14;
        #1;
        check("midclr_ready", 32'(rdy[0]), 32'd1);
        check("midclr_rd_a", 32'(rda[0]), 32'h0);
        check("midclr_rd_b", 32'(rdb[1]), 32'h0);
        step();
        rst = 1'b0;
        wb_valid = 1'b1; wb_addr = 4'd9; wb_data = 16'h5A5A; rd_addr_a = 4'd9;
        step();
        wb_valid = 1'b0;
        #1;
        check("post_rst_wb", 32'(rda[0]), 32'h5A5A);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rand_inputs(40);
            step();
        end
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
